// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with filtered SCL/SDA, 7-bit address match and byte strobes to local logic.
// Latency: 2+FILTER clk from pin to filtered edge; SDA is updated on the clk after a filtered SCL fall.
// Backpressure: none by default; with I2C_SLAVE_STRETCH_EN, SCL is held low until txvalid confirms a read byte.
//
// Optional feature macro: I2C_SLAVE_STRETCH_EN (clock stretching on read-byte latch).
// Ports: clk, reset (async active-low); sda/scl open-drain inouts (driven 0 or Z);
//        addressed/rw report the current match; rxdata/rxvalid deliver written bytes;
//        txreq asks for the next read byte on txdata; txvalid confirms it (stretch build only);
//        busy is high between START and STOP.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER     = 3
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        sda,
    inout  wire        scl,
    output logic       addressed,
    output logic       rw,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    output logic       txreq,
    input  logic [7:0] txdata,
    input  logic       txvalid,
    output logic       busy
);

    localparam logic [3:0] FLT_LAST = 4'(FILTER - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    // ---------------- input synchronizer and glitch filter ----------------
    logic [1:0] sda_sync, scl_sync;
    logic [3:0] sda_cnt, scl_cnt;
    logic       sda_f, scl_f, sda_p, scl_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sda_sync <= 2'b11;
            scl_sync <= 2'b11;
            sda_cnt  <= '0;
            scl_cnt  <= '0;
            sda_f    <= 1'b1;
            scl_f    <= 1'b1;
            sda_p    <= 1'b1;
            scl_p    <= 1'b1;
        end else begin
            sda_sync <= {sda_sync[0], sda};
            scl_sync <= {scl_sync[0], scl};
            sda_p    <= sda_f;
            scl_p    <= scl_f;
            // A filtered line only follows the synchronized one after FILTER
            // consecutive disagreeing samples; any agreeing sample restarts the count.
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FLT_LAST) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 4'd1;
            end
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FLT_LAST) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 4'd1;
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_p;
    assign scl_fall  = ~scl_f & scl_p;
    assign start_det = scl_f & scl_p & sda_p & ~sda_f;
    assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

    // tx_ok: may the read byte be latched in this clk
    logic tx_ok;
`ifdef I2C_SLAVE_STRETCH_EN
    assign tx_ok = txvalid;
`else
    logic txvalid_unused;
    assign txvalid_unused = txvalid;
    assign tx_ok = 1'b1;
`endif

    // ---------------- protocol FSM ----------------
    state_t     state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [6:0] rxsh, rxsh_n;
    logic [6:0] txsh, txsh_n;      // remaining read bits, MSB is the next to drive
    logic [7:0] rxdata_n, rxbyte;
    logic       phase, phase_n;    // ACK states: 0 = before first SCL fall / before ACK rise
    logic       sda_oe, sda_oe_n, scl_oe, scl_oe_n, wait_tx, wait_tx_n;
    logic       addressed_n, rw_n, rxvalid_n, txreq_n, busy_n;
    logic       tx_due, tx_load;

    assign rxbyte = {rxsh, sda_f};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bitcnt    <= 3'd7;
            rxsh      <= '0;
            txsh      <= '0;
            rxdata    <= 8'h00;
            phase     <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            wait_tx   <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            rxvalid   <= 1'b0;
            txreq     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            rxsh      <= rxsh_n;
            txsh      <= txsh_n;
            rxdata    <= rxdata_n;
            phase     <= phase_n;
            sda_oe    <= sda_oe_n;
            scl_oe    <= scl_oe_n;
            wait_tx   <= wait_tx_n;
            addressed <= addressed_n;
            rw        <= rw_n;
            rxvalid   <= rxvalid_n;
            txreq     <= txreq_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        bitcnt_n    = bitcnt;
        rxsh_n      = rxsh;
        txsh_n      = txsh;
        rxdata_n    = rxdata;
        phase_n     = phase;
        sda_oe_n    = sda_oe;
        wait_tx_n   = wait_tx;
        addressed_n = addressed;
        rw_n        = rw;
        busy_n      = busy;
        rxvalid_n   = 1'b0;
        txreq_n     = 1'b0;
        tx_due      = 1'b0;
        tx_load     = 1'b0;

        // Bus conditions override any bit activity in the same clk.
        if (start_det) begin
            state_n   = ADDR;
            bitcnt_n  = 3'd7;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b1;
            phase_n   = 1'b0;
            wait_tx_n = 1'b0;
        end else if (stop_det) begin
            state_n     = IDLE;
            sda_oe_n    = 1'b0;
            addressed_n = 1'b0;
            busy_n      = 1'b0;
            phase_n     = 1'b0;
            wait_tx_n   = 1'b0;
        end else if (wait_tx) begin
            // SCL is held low by us, so no bus edges can arrive while waiting.
            tx_load = tx_ok;
        end else begin
            case (state)
                IDLE: ;
                ADDR: if (scl_rise) begin
                    rxsh_n   = rxbyte[6:0];
                    bitcnt_n = bitcnt - 3'd1;
                    if (bitcnt == 3'd0) begin
                        phase_n = 1'b0;
                        if (rxbyte[7:1] == SLAVE_ADDR) begin
                            rw_n        = rxbyte[0];
                            addressed_n = 1'b1;
                            txreq_n     = rxbyte[0];
                            state_n     = ADDR_ACK;
                        end else begin
                            addressed_n = 1'b0;
                            state_n     = IGNORE;
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_n = 1'b1;
                        phase_n  = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        bitcnt_n = 3'd7;
                        if (state == ADDR_ACK && rw) tx_due = 1'b1;
                        else                         state_n = WRITE;
                    end
                end
                WRITE: if (scl_rise) begin
                    rxsh_n   = rxbyte[6:0];
                    bitcnt_n = bitcnt - 3'd1;
                    if (bitcnt == 3'd0) begin
                        rxdata_n  = rxbyte;
                        rxvalid_n = 1'b1;
                        phase_n   = 1'b0;
                        state_n   = WRITE_ACK;
                    end
                end
                READ: if (scl_fall) begin
                    if (bitcnt == 3'd0) begin
                        sda_oe_n = 1'b0;
                        phase_n  = 1'b0;
                        state_n  = READ_ACK;
                    end else begin
                        sda_oe_n = ~txsh[6];
                        txsh_n   = {txsh[5:0], 1'b0};
                        bitcnt_n = bitcnt - 3'd1;
                    end
                end
                READ_ACK: begin
                    if (!phase) begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                txreq_n = 1'b1;
                                phase_n = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        phase_n = 1'b0;
                        tx_due  = 1'b1;
                    end
                end
                IGNORE: sda_oe_n = 1'b0;
                default: state_n = IDLE;
            endcase

            if (tx_due) begin
                if (tx_ok) begin
                    tx_load = 1'b1;
                end else begin
                    wait_tx_n = 1'b1;
                    sda_oe_n  = 1'b0;
                end
            end
        end

        if (tx_load) begin
            txsh_n    = txdata[6:0];
            sda_oe_n  = ~txdata[7];
            bitcnt_n  = 3'd7;
            state_n   = READ;
            wait_tx_n = 1'b0;
        end

        // SCL stays low for the whole wait plus the clk in which the byte is latched.
        scl_oe_n = wait_tx | wait_tx_n;
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign scl = scl_oe ? 1'b0 : 1'bz;

endmodule
